// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty levels.
// Define SYNC_FIFO_PROG_FWFT_EN for first-word-fall-through read data.
module sync_fifo_prog #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             walmost_full,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             ralmost_empty,
    input  logic [ASIZE:0]   af_thresh,
    input  logic [ASIZE:0]   ae_thresh,
    output logic [ASIZE:0]   count,
    input  logic             err_clr,
    output logic             overflow,
    output logic             underflow
);

    localparam int DEPTH = 1 << ASIZE;
    localparam int PW    = ASIZE + 1;
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);

    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic [DSIZE-1:0] mem_q [DEPTH];

    logic             full_w, empty_w;
    logic             wr_acc, rd_acc;
    logic [ASIZE-1:0] waddr, raddr;

    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == '0);
    assign waddr   = wptr_q[ASIZE-1:0];
    assign raddr   = rptr_q[ASIZE-1:0];

    // Flush discards any same-cycle transfer.
    assign wr_acc = winc && !full_w && !flush;
    assign rd_acc = rinc && !empty_w && !flush;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + 1'b1;
            if (rd_acc) rptr_d = rptr_q + 1'b1;
        end
        // A new error outranks a same-cycle clear.
        if (err_clr) ovf_d = 1'b0;
        if (err_clr) udf_d = 1'b0;
        if (winc && full_w) ovf_d = 1'b1;
        if (rinc && empty_w) udf_d = 1'b1;
        count_d = wptr_d - rptr_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[waddr] <= wdata;
    end

`ifdef SYNC_FIFO_PROG_FWFT_EN
    assign rdata = mem_q[raddr];
`else
    logic [DSIZE-1:0] rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (flush) begin
            rdata_q <= '0;
        end else if (rd_acc) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;
`endif

    assign count         = count_q;
    assign wfull         = full_w;
    assign rempty        = empty_w;
    assign walmost_full  = (count_q >= af_thresh);
    assign ralmost_empty = (count_q <= ae_thresh);
    assign overflow      = ovf_q;
    assign underflow     = udf_q;

endmodule
